vreg_wb_arb: RTL and testbench
==============================

VREG_WB_ARB -- requirements
Module: vreg_wb_arb

Interface
REQ-001 Parameter DATA_W, default 256, SHALL set the vector register data width in bits.
REQ-002 Parameter LEN_W, default 4, SHALL set the vector length field width in bits.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 alu_valid / alu_ready  input / output  1 / 1  SHALL form the ALU writeback handshake.
REQ-006 alu_addr / alu_len / alu_data  input  4 / LEN_W / DATA_W  SHALL carry the ALU destination register, length and data.
REQ-007 mem_valid / mem_ready  input / output  1 / 1  SHALL form the memory-load writeback handshake.
REQ-008 mem_addr / mem_len / mem_data  input  4 / LEN_W / DATA_W  SHALL carry the load destination register, length and data.
REQ-009 wEn / wAddr / wLen / wData  output  1 / 4 / LEN_W / DATA_W  SHALL drive the vector register file write port.
REQ-010 alloc_en / alloc_addr  input  1 / 4  SHALL mark a destination register as pending a write (issue stage).
REQ-011 busy  output  16  SHALL give one pending-write bit per vector register.
REQ-012 unalloc_wr  output  1  SHALL be a sticky flag set on a write to a register whose busy bit is clear.

Function
REQ-013 A requester transfer SHALL occur in a cycle where its valid and ready are both high.
REQ-014 The block SHALL always be able to accept one transfer per cycle; there is no backpressure from the register file.
REQ-015 ready SHALL be combinational: at most one of alu_ready and mem_ready is high, and only for a requester whose valid is high.
REQ-016 With only one valid requester, that requester SHALL be granted in the same cycle.
REQ-017 The accepted addr/len/data SHALL be registered; wEn SHALL be high for exactly one cycle, on the cycle after acceptance, with matching wAddr/wLen/wData.
REQ-018 With no transfer, wEn SHALL be 0 on the next cycle; wAddr/wLen/wData SHALL hold their last values.
REQ-019 Both valid, VREG_WB_RR_EN defined: grant SHALL go to the requester not granted most recently.
REQ-020 The round-robin pointer SHALL update only on a transfer; it SHALL hold while neither requester is valid.
REQ-021 A requester SHALL keep its valid and payload stable until its transfer occurs; the block does not check this.
REQ-022 alloc_en SHALL set busy[alloc_addr] at the next edge.
REQ-023 When wEn is high, busy[wAddr] SHALL clear at the same edge that commits the write.
REQ-024 Simultaneous set and clear of the same busy bit SHALL leave it set; the new producer wins.
REQ-025 A transfer whose addr has its busy bit clear SHALL still be written, and SHALL set unalloc_wr one cycle later.
REQ-026 unalloc_wr SHALL remain set until reset.
REQ-027 Two transfers to the same register in consecutive cycles SHALL produce two wEn pulses in acceptance order; the last one wins.

Reset
REQ-028 While rst_n is low, all of the following SHALL be 0: wEn, wAddr, wLen, wData, busy, unalloc_wr.
REQ-029 The round-robin pointer SHALL reset so that the ALU wins the first contended grant.
REQ-030 Reset asserted mid-operation SHALL drop any registered, not-yet-issued write; no wEn pulse follows reset release.
REQ-031 ready outputs SHALL be 0 while rst_n is low.

Configuration
REQ-032 Macro VREG_WB_RR_EN defined: arbitration SHALL be round-robin per REQ-019/REQ-020.
REQ-033 Macro VREG_WB_RR_EN undefined: arbitration SHALL be fixed priority, with the ALU always winning and no pointer state; all other behaviour is unchanged.

Verification
REQ-034 Single ALU write: alu_valid=1, addr=3, len=8, data=0xA5..A5 for one cycle -> alu_ready=1 that cycle; next cycle wEn=1, wAddr=3, wLen=8, wData=0xA5..A5; following cycle wEn=0.
REQ-035 Contention with RR: both valid for 4 cycles (alu addr=1, mem addr=2) -> grants ALU, MEM, ALU, MEM; wAddr sequence 1, 2, 1, 2.
REQ-036 Contention without RR: same stimulus -> 4 ALU grants, mem_ready=0 throughout; MEM granted in the first cycle after alu_valid drops.
REQ-037 Scoreboard: alloc_en addr=5, then a mem write to 5 -> busy[5]=1 the cycle after alloc, cleared at the edge where wEn with wAddr=5 commits; alloc of 5 in the same cycle as that wEn -> busy[5] stays 1.
REQ-038 Unallocated write: ALU write to addr=9 with busy[9]=0 -> write occurs and unalloc_wr=1 from the next cycle until reset.
REQ-039 Reset mid-flight: assert rst_n=0 in the cycle after a transfer is accepted -> wEn=0 and busy=0 immediately; no wEn pulse after release.

Source files
------------

// File: rtl/vreg_wb_arb_if.sv
// vreg_wb_arb_if: writeback arbiter bus bundle (macro VREG_WB_RR_EN selects arbitration in vreg_wb_arb)
//   alu_*     : ALU writeback request (valid/ready, addr, len, data)
//   mem_*     : memory-load writeback request (valid/ready, addr, len, data)
//   wEn..wData: vector register file write port
//   alloc_*   : issue-stage pending-write allocation
//   busy      : per-register pending-write scoreboard
//   unalloc_wr: sticky flag for writes to non-pending registers
//   modport slave is the arbiter's view, modport master the requesters'/environment's view
interface vreg_wb_arb_if #(
   parameter int DATA_W = 256,
   parameter int LEN_W  = 4
);
   logic              alu_valid;
   logic              alu_ready;
   logic [3:0]        alu_addr;
   logic [LEN_W-1:0]  alu_len;
   logic [DATA_W-1:0] alu_data;
   logic              mem_valid;
   logic              mem_ready;
   logic [3:0]        mem_addr;
   logic [LEN_W-1:0]  mem_len;
   logic [DATA_W-1:0] mem_data;
   logic              wEn;
   logic [3:0]        wAddr;
   logic [LEN_W-1:0]  wLen;
   logic [DATA_W-1:0] wData;
   logic              alloc_en;
   logic [3:0]        alloc_addr;
   logic [15:0]       busy;
   logic              unalloc_wr;
   modport slave (
      input  alu_valid, alu_addr, alu_len, alu_data,
      input  mem_valid, mem_addr, mem_len, mem_data,
      input  alloc_en, alloc_addr,
      output alu_ready, mem_ready, wEn, wAddr, wLen, wData, busy, unalloc_wr
   );
   modport master (
      output alu_valid, alu_addr, alu_len, alu_data,
      output mem_valid, mem_addr, mem_len, mem_data,
      output alloc_en, alloc_addr,
      input  alu_ready, mem_ready, wEn, wAddr, wLen, wData, busy, unalloc_wr
   );
endinterface

// File: rtl/vreg_wb_arb.sv
// vreg_wb_arb: two-requester vector register writeback arbiter with pending-write scoreboard
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : vreg_wb_arb_if.slave (ALU/MEM requests, register file write port, alloc, busy, unalloc_wr)
//   Macro VREG_WB_RR_EN: defined -> round-robin between ALU and MEM; undefined -> ALU fixed priority
module vreg_wb_arb #(
   parameter int DATA_W = 256,
   parameter int LEN_W  = 4
) (
   input logic          clk,
   input logic          rst_n,
   vreg_wb_arb_if.slave bus
);
   logic              alu_gnt;
   logic              mem_gnt;
   logic              xfer;
   logic [3:0]        sel_addr;
   logic              wen_q, wen_d;
   logic [3:0]        waddr_q, waddr_d;
   logic [LEN_W-1:0]  wlen_q, wlen_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [15:0]       busy_q, busy_d;
   logic              unalloc_q, unalloc_d;
`ifdef VREG_WB_RR_EN
   // set when MEM won the last transfer; resets high so the ALU wins the first contest
   logic              last_mem_q, last_mem_d;
`endif
   always_comb begin
`ifdef VREG_WB_RR_EN
      alu_gnt = rst_n & bus.alu_valid & (~bus.mem_valid | last_mem_q);
`else
      alu_gnt = rst_n & bus.alu_valid;
`endif
      mem_gnt = rst_n & bus.mem_valid & ~alu_gnt;
      xfer = alu_gnt | mem_gnt;
      sel_addr = alu_gnt ? bus.alu_addr : bus.mem_addr;
      wen_d = xfer;
      waddr_d = xfer ? sel_addr : waddr_q;
      wlen_d = xfer ? (alu_gnt ? bus.alu_len : bus.mem_len) : wlen_q;
      wdata_d = xfer ? (alu_gnt ? bus.alu_data : bus.mem_data) : wdata_q;
      // alloc is OR-ed after the commit clear so a new producer wins a same-cycle collision
      busy_d = (busy_q & ~(wen_q ? 16'(1) << waddr_q : 16'h0)) |
               (bus.alloc_en ? 16'(1) << bus.alloc_addr : 16'h0);
      unalloc_d = unalloc_q | (xfer & ~busy_q[sel_addr]);
`ifdef VREG_WB_RR_EN
      last_mem_d = xfer ? mem_gnt : last_mem_q;
`endif
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wen_q <= 1'b0;
         waddr_q <= '0;
         wlen_q <= '0;
         wdata_q <= '0;
         busy_q <= '0;
         unalloc_q <= 1'b0;
`ifdef VREG_WB_RR_EN
         last_mem_q <= 1'b1;
`endif
      end else begin
         wen_q <= wen_d;
         waddr_q <= waddr_d;
         wlen_q <= wlen_d;
         wdata_q <= wdata_d;
         busy_q <= busy_d;
         unalloc_q <= unalloc_d;
`ifdef VREG_WB_RR_EN
         last_mem_q <= last_mem_d;
`endif
      end
   end
   assign bus.alu_ready = alu_gnt;
   assign bus.mem_ready = mem_gnt;
   assign bus.wEn = wen_q;
   assign bus.wAddr = waddr_q;
   assign bus.wLen = wlen_q;
   assign bus.wData = wdata_q;
   assign bus.busy = busy_q;
   assign bus.unalloc_wr = unalloc_q;
endmodule

// File: tb/tb_vreg_wb_arb.sv
// tb_vreg_wb_arb: directed and randomized bench for vreg_wb_arb with a rule-level reference model
module tb_vreg_wb_arb;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int checks = 0;
   int failures = 0;
   bit g_alu, g_mem;
   bit m_wen, m_unalloc, m_last_mem;
   logic [3:0] m_waddr, m_wlen;
   logic [255:0] m_wdata;
   bit m_busy [16];
   logic [255:0] d1, d2;
   int exp_a;

   vreg_wb_arb_if #(.DATA_W(256), .LEN_W(4)) bus ();
   vreg_wb_arb #(.DATA_W(256), .LEN_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] rnd256();
      logic [255:0] r;
      for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [15:0] busy_vec();
      logic [15:0] v;
      for (int k = 0; k < 16; k++) v[k] = m_busy[k];
      return v;
   endfunction

   task automatic model_reset();
      m_wen = 0; m_waddr = 0; m_wlen = 0; m_wdata = 0;
      m_unalloc = 0; m_last_mem = 1;
      for (int k = 0; k < 16; k++) m_busy[k] = 0;
   endtask

   task automatic idle_inputs();
      bus.alu_valid = 0; bus.alu_addr = 0; bus.alu_len = 0; bus.alu_data = 0;
      bus.mem_valid = 0; bus.mem_addr = 0; bus.mem_len = 0; bus.mem_data = 0;
      bus.alloc_en = 0; bus.alloc_addr = 0;
   endtask

   // one clock: check grants before the edge, advance the model, check registered outputs after it
   task automatic step();
      bit al, xf, was_busy;
      logic [3:0] aa, la, ll;
      logic [255:0] ld;
      #4;
`ifdef VREG_WB_RR_EN
      g_alu = bus.alu_valid && (!bus.mem_valid || m_last_mem);
`else
      g_alu = bus.alu_valid;
`endif
      g_mem = bus.mem_valid && !g_alu;
      chk("alu_ready", bus.alu_ready, g_alu);
      chk("mem_ready", bus.mem_ready, g_mem);
      xf = g_alu || g_mem;
      la = g_alu ? bus.alu_addr : bus.mem_addr;
      ll = g_alu ? bus.alu_len : bus.mem_len;
      ld = g_alu ? bus.alu_data : bus.mem_data;
      al = bus.alloc_en;
      aa = bus.alloc_addr;
      was_busy = m_busy[la];
      @(posedge clk);
      #1;
      if (m_wen) m_busy[m_waddr] = 0;
      if (al) m_busy[aa] = 1;
      if (xf && !was_busy) m_unalloc = 1;
      m_wen = xf;
      if (xf) begin
         m_waddr = la; m_wlen = ll; m_wdata = ld; m_last_mem = g_mem;
      end
      chk("wEn", bus.wEn, m_wen);
      chk("wAddr", bus.wAddr, m_waddr);
      chk("wLen", bus.wLen, m_wlen);
      chk("wData", bus.wData, m_wdata);
      chk("busy", bus.busy, busy_vec());
      chk("unalloc_wr", bus.unalloc_wr, m_unalloc);
   endtask

   task automatic do_reset();
      rst_n = 0;
      bus.alu_valid = 1; bus.mem_valid = 1; bus.alloc_en = 0;
      #1;
      chk("rst_alu_ready", bus.alu_ready, 0);
      chk("rst_mem_ready", bus.mem_ready, 0);
      chk("rst_wEn", bus.wEn, 0);
      chk("rst_wAddr", bus.wAddr, 0);
      chk("rst_wLen", bus.wLen, 0);
      chk("rst_wData", bus.wData, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_unalloc", bus.unalloc_wr, 0);
      idle_inputs();
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1;
      model_reset();
   endtask

   initial begin
      idle_inputs();
      model_reset();
      #1;
      do_reset();
      // single ALU write
      bus.alu_valid = 1; bus.alu_addr = 3; bus.alu_len = 8; bus.alu_data = {32{8'hA5}};
      step();
      idle_inputs();
      chk("single_wEn", bus.wEn, 1);
      chk("single_wAddr", bus.wAddr, 3);
      chk("single_wLen", bus.wLen, 8);
      chk("single_wData", bus.wData, {32{8'hA5}});
      step();
      chk("single_wEn_drop", bus.wEn, 0);
      chk("single_wData_hold", bus.wData, {32{8'hA5}});
      // contention
      do_reset();
      bus.alu_valid = 1; bus.alu_addr = 1; bus.alu_len = 1; bus.alu_data = 256'h11;
      bus.mem_valid = 1; bus.mem_addr = 2; bus.mem_len = 2; bus.mem_data = 256'h22;
      for (int i = 0; i < 4; i++) begin
`ifdef VREG_WB_RR_EN
         exp_a = (i % 2 == 0) ? 1 : 2;
`else
         exp_a = 1;
`endif
         step();
         chk("contend_wAddr", bus.wAddr, 4'(exp_a));
      end
      bus.alu_valid = 0;
      step();
      chk("contend_mem_after", bus.wAddr, 2);
      idle_inputs();
      step();
      // scoreboard
      do_reset();
      bus.alloc_en = 1; bus.alloc_addr = 5;
      step();
      bus.alloc_en = 0;
      chk("sb_alloc", bus.busy[5], 1);
      bus.mem_valid = 1; bus.mem_addr = 5; bus.mem_len = 2; bus.mem_data = rnd256();
      step();
      bus.mem_valid = 0;
      chk("sb_wen", bus.wEn, 1);
      chk("sb_busy_pending", bus.busy[5], 1);
      step();
      chk("sb_busy_clear", bus.busy[5], 0);
      bus.alloc_en = 1;
      step();
      bus.alloc_en = 0;
      bus.mem_valid = 1; bus.mem_data = rnd256();
      step();
      bus.mem_valid = 0;
      bus.alloc_en = 1;
      step();
      bus.alloc_en = 0;
      chk("sb_set_wins", bus.busy[5], 1);
      chk("sb_no_unalloc", bus.unalloc_wr, 0);
      // consecutive writes to one register
      do_reset();
      bus.alloc_en = 1; bus.alloc_addr = 7;
      step();
      bus.alloc_en = 0;
      d1 = rnd256();
      d2 = rnd256();
      bus.alu_valid = 1; bus.alu_addr = 7; bus.alu_len = 3; bus.alu_data = d1;
      step();
      chk("b2b_first", bus.wData, d1);
      bus.alu_data = d2;
      step();
      chk("b2b_second", bus.wData, d2);
      bus.alu_valid = 0;
      step();
      chk("b2b_idle_wEn", bus.wEn, 0);
      chk("b2b_hold", bus.wData, d2);
      // unallocated write
      do_reset();
      bus.alu_valid = 1; bus.alu_addr = 9; bus.alu_len = 1; bus.alu_data = rnd256();
      step();
      bus.alu_valid = 0;
      chk("unalloc_wAddr", bus.wAddr, 9);
      chk("unalloc_set", bus.unalloc_wr, 1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("unalloc_sticky", bus.unalloc_wr, 1);
      end
      // reset mid-flight
      do_reset();
      bus.alloc_en = 1; bus.alloc_addr = 4;
      step();
      bus.alloc_en = 0;
      bus.alu_valid = 1; bus.alu_addr = 4; bus.alu_len = 5; bus.alu_data = rnd256();
      step();
      bus.alu_valid = 0;
      chk("mid_wEn_before", bus.wEn, 1);
      rst_n = 0;
      #1;
      chk("mid_wEn_rst", bus.wEn, 0);
      chk("mid_busy_rst", bus.busy, 0);
      model_reset();
      @(posedge clk);
      #1 rst_n = 1;
      for (int i = 0; i < 3; i++) step();
      // randomized traffic honouring valid/payload stability until transfer
      do_reset();
      for (int i = 0; i < 400; i++) begin
         if (!bus.alu_valid || g_alu) begin
            bus.alu_valid = $urandom_range(0, 99) < 60;
            bus.alu_addr = 4'($urandom);
            bus.alu_len = 4'($urandom);
            bus.alu_data = rnd256();
         end
         if (!bus.mem_valid || g_mem) begin
            bus.mem_valid = $urandom_range(0, 99) < 60;
            bus.mem_addr = 4'($urandom);
            bus.mem_len = 4'($urandom);
            bus.mem_data = rnd256();
         end
         bus.alloc_en = $urandom_range(0, 99) < 40;
         bus.alloc_addr = 4'($urandom);
         step();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
